// File: rtl/uart_pkg.sv
// Shared types and helpers for the byte-wide UART transmitter.
// Holds the FSM state encoding, parity mode constants and the baud divisor helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Bit period in clock cycles, rounded to the nearest integer.
  function automatic int calc_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: tick_o marks the last cycle of each DIV-cycle period,
// pre_tick_o the cycle before it. restart_i realigns the period to a frame start.
module baud_tick_gen #(
  parameter int DIV = 868
) (
  input  logic clk_100,
  input  logic Reset_n,
  input  logic restart_i,
  output logic tick_o,
  output logic pre_tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DIV - 1);
  localparam logic [CW-1:0] PRE_CNT  = CW'(DIV - 2);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_100) begin
    if (!Reset_n || restart_i) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST_CNT) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o     = (cnt_q == LAST_CNT);
  assign pre_tick_o = (cnt_q == PRE_CNT);

endmodule

// File: rtl/uart_byte_tx.sv
// UART byte transmitter with a one-byte holding register so consecutive frames
// go out back-to-back. All outputs come straight from flops.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk_100,
  input  logic       Reset_n,
  input  logic       tx_en,
  input  logic [7:0] tx_byte,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_active,
  output logic       tx_done,
  output logic       tx_overrun
);

  localparam int          DIV       = calc_div(CLK_FREQ, BAUD);
  localparam logic [7:0]  DATA_MASK = 8'((1 << DATA_BITS) - 1);
  localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic        LAST_STOP = 1'(STOP_BITS - 1);

  tx_state_e  state_q;
  logic [7:0] shift_q;
  logic [7:0] hold_q;
  logic       busy_q;
  logic [2:0] bit_cnt_q;
  logic       stop_cnt_q;
  logic       par_q;
  logic       tx_q;
  logic       active_q;
  logic       done_q;
  logic       ovr_q;

  logic       tick;
  logic       pre_tick;
  logic       accept;
  logic       last_stop;
  logic       frame_end;
  logic       load_direct;
  logic       load_hold;
  logic       hold_write;
  logic       restart;
  logic [7:0] load_byte_d;

  baud_tick_gen #(
    .DIV (DIV)
  ) u_baud (
    .clk_100    (clk_100),
    .Reset_n    (Reset_n),
    .restart_i  (restart),
    .tick_o     (tick),
    .pre_tick_o (pre_tick)
  );

  assign accept    = tx_en && !busy_q;
  assign last_stop = (state_q == ST_STOP) && (stop_cnt_q == LAST_STOP);
  assign frame_end = last_stop && tick;

  // A byte arriving on the frame-end edge with the holder empty skips the holder.
  assign load_direct = accept && ((state_q == ST_IDLE) || frame_end);
  assign load_hold   = frame_end && busy_q;
  assign hold_write  = accept && !load_direct;
  assign restart     = load_direct || load_hold;
  assign load_byte_d = load_hold ? hold_q : (tx_byte & DATA_MASK);

  always_ff @(posedge clk_100) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      hold_q     <= '0;
      busy_q     <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      // Registered, so the pulse lands in the final cycle of the last stop bit.
      done_q <= last_stop && pre_tick;
      ovr_q  <= tx_en && busy_q;

      if (hold_write) begin
        hold_q <= tx_byte & DATA_MASK;
        busy_q <= 1'b1;
      end

      if (restart) begin
        shift_q    <= load_byte_d;
        par_q      <= ^load_byte_d;
        bit_cnt_q  <= '0;
        stop_cnt_q <= 1'b0;
        state_q    <= ST_START;
        tx_q       <= 1'b0;
        active_q   <= 1'b1;
        if (load_hold) begin
          busy_q <= 1'b0;
        end
      end else if (tick) begin
        case (state_q)
          ST_START: begin
            state_q <= ST_DATA;
            tx_q    <= shift_q[0];
          end
          ST_DATA: begin
            if (bit_cnt_q == LAST_BIT) begin
              if (PARITY != PAR_NONE) begin
                state_q <= ST_PARITY;
                tx_q    <= (PARITY == PAR_EVEN) ? par_q : ~par_q;
              end else begin
                state_q <= ST_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
            end
          end
          ST_PARITY: begin
            state_q <= ST_STOP;
            tx_q    <= 1'b1;
          end
          ST_STOP: begin
            if (stop_cnt_q == LAST_STOP) begin
              state_q  <= ST_IDLE;
              active_q <= 1'b0;
            end else begin
              stop_cnt_q <= stop_cnt_q + 1'b1;
            end
            tx_q <= 1'b1;
          end
          default: begin
            tx_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign tx         = tx_q;
  assign tx_busy    = busy_q;
  assign tx_active  = active_q;
  assign tx_done    = done_q;
  assign tx_overrun = ovr_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx at DIV=8: three instances cover no parity/1 stop,
// even parity/1 stop and odd parity/2 stop. Expected bytes ride a scoreboard queue.
module tb_uart_byte_tx;

  localparam int DIV = 8;

  logic       clk;
  logic       rst_n;
  logic [2:0] tx_en_v;
  logic [7:0] tx_byte;
  logic [2:0] tx_v, busy_v, act_v, done_v, ovr_v;

  logic [7:0] exp_q [$];
  int checks = 0;
  int passed = 0;

  uart_byte_tx #(.CLK_FREQ(100_000_000), .BAUD(12_500_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_p0 (
    .clk_100(clk), .Reset_n(rst_n), .tx_en(tx_en_v[0]), .tx_byte(tx_byte),
    .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_active(act_v[0]), .tx_done(done_v[0]), .tx_overrun(ovr_v[0]));

  uart_byte_tx #(.CLK_FREQ(100_000_000), .BAUD(12_500_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_pe (
    .clk_100(clk), .Reset_n(rst_n), .tx_en(tx_en_v[1]), .tx_byte(tx_byte),
    .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_active(act_v[1]), .tx_done(done_v[1]), .tx_overrun(ovr_v[1]));

  uart_byte_tx #(.CLK_FREQ(100_000_000), .BAUD(12_500_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u_po (
    .clk_100(clk), .Reset_n(rst_n), .tx_en(tx_en_v[2]), .tx_byte(tx_byte),
    .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_active(act_v[2]), .tx_done(done_v[2]), .tx_overrun(ovr_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level in cycle k (1-based from the accepting edge) of a frame.
  function automatic logic exp_line(input logic [7:0] b, input int par, input int k);
    int idx;
    idx = (k - 1) / DIV;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (par != 0 && idx == 9) return (par == 2) ? ^b : ~^b;
    return 1'b1;
  endfunction

  task automatic start_byte(input int sel, input logic [7:0] b);
    tx_en_v[sel] = 1'b1;
    tx_byte = b;
    exp_q.push_back(b);
    @(negedge clk);
    tx_en_v[sel] = 1'b0;
  endtask

  // Pops one expected byte and follows its frame cycle by cycle; optionally
  // offers a second byte at cycle inj_k and a refused byte at cycle ovr_k.
  task automatic check_frame(input int sel, input int par, input int stops, input int inj_k,
                             input logic [7:0] inj_b, input int ovr_k, input string name);
    logic [7:0] b;
    int len;
    logic got [5];
    logic want [5];
    int err [5];
    int fk [5];
    logic fg [5];
    logic fw [5];
    string sig_n [5];
    sig_n = '{"tx", "tx_done", "tx_active", "tx_busy", "tx_overrun"};
    len = DIV * (1 + 8 + ((par != 0) ? 1 : 0) + stops);
    for (int s = 0; s < 5; s++) begin err[s] = 0; fk[s] = 0; fg[s] = 1'b0; fw[s] = 1'b0; end
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s scoreboard: queue has 0 bytes, required 1", name);
      b = 8'h00;
    end else begin
      b = exp_q.pop_front();
      passed++;
    end
    for (int k = 1; k <= len; k++) begin
      got  = '{tx_v[sel], done_v[sel], act_v[sel], busy_v[sel], ovr_v[sel]};
      want = '{exp_line(b, par, k), (k == len), 1'b1,
               (inj_k > 0 && inj_k < len && k > inj_k), (ovr_k > 0 && k == ovr_k + 1)};
      for (int s = 0; s < 5; s++) begin
        if (got[s] !== want[s]) begin
          if (err[s] == 0) begin fk[s] = k; fg[s] = got[s]; fw[s] = want[s]; end
          err[s]++;
        end
      end
      if (k == inj_k) begin
        tx_en_v[sel] = 1'b1;
        tx_byte = inj_b;
        exp_q.push_back(inj_b);
      end else if (k == ovr_k) begin
        tx_en_v[sel] = 1'b1;
        tx_byte = 8'h33;
      end else begin
        tx_en_v[sel] = 1'b0;
      end
      @(negedge clk);
    end
    tx_en_v[sel] = 1'b0;
    for (int s = 0; s < 5; s++) begin
      checks++;
      if (err[s] != 0)
        $display("FAIL %s %s (byte %02h): %0d bad cycles, first at cycle %0d got %b required %b",
                 name, sig_n[s], b, err[s], fk[s], fg[s], fw[s]);
      else
        passed++;
    end
    $display("frame %s byte %02h on dut %0d: %0d cycles", name, b, sel, len);
  endtask

  task automatic check_idle(input int sel, input string name);
    checks++;
    if (tx_v[sel] !== 1'b1 || act_v[sel] !== 1'b0 || done_v[sel] !== 1'b0 || busy_v[sel] !== 1'b0)
      $display("FAIL %s idle: tx/active/done/busy got %b%b%b%b required 1000",
               name, tx_v[sel], act_v[sel], done_v[sel], busy_v[sel]);
    else
      passed++;
  endtask

  task automatic test_reset();
    int bad;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({tx_v, busy_v, act_v, done_v, ovr_v} !== {3'b111, 12'b0})
        $display("FAIL reset_cycle%0d: outputs got %b required %b", c,
                 {tx_v, busy_v, act_v, done_v, ovr_v}, {3'b111, 12'b0});
      else
        passed++;
    end
    rst_n = 1'b1;
    tx_en_v = 3'b000;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (tx_v !== 3'b111 || act_v !== 3'b000 || done_v !== 3'b000) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL reset_release: %0d cycles with activity, required 0", bad);
    else passed++;
    $display("reset: held 3 cycles with tx_en high, then 20 idle cycles observed");
  endtask

  task automatic test_single();
    start_byte(0, 8'hA5);
    check_frame(0, 0, 1, 0, 8'h00, 0, "single_a5");
    check_idle(0, "single_a5");
  endtask

  task automatic test_back_to_back();
    start_byte(0, 8'h00);
    check_frame(0, 0, 1, 20, 8'hFF, 0, "b2b_first");
    check_frame(0, 0, 1, 0, 8'h00, 0, "b2b_second");
    check_idle(0, "b2b");
  endtask

  task automatic test_frame_end_accept();
    start_byte(0, 8'h5C);
    check_frame(0, 0, 1, 80, 8'hC5, 0, "fe_first");
    check_frame(0, 0, 1, 0, 8'h00, 0, "fe_second");
    check_idle(0, "fe");
  endtask

  task automatic test_parity();
    start_byte(1, 8'h07);
    check_frame(1, 2, 1, 0, 8'h00, 0, "par_even");
    check_idle(1, "par_even");
    start_byte(2, 8'h07);
    check_frame(2, 1, 2, 0, 8'h00, 0, "par_odd_2stop");
    check_idle(2, "par_odd_2stop");
  endtask

  task automatic test_overrun();
    start_byte(0, 8'h3C);
    check_frame(0, 0, 1, 20, 8'h96, 30, "ovr_first");
    check_frame(0, 0, 1, 0, 8'h00, 0, "ovr_second");
    check_idle(0, "ovr");
    checks++;
    if (exp_q.size() != 0) $display("FAIL ovr_queue: %0d bytes left, required 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_mid_reset();
    int bad;
    logic [7:0] b;
    start_byte(0, 8'hC3);
    b = exp_q[0];
    bad = 0;
    for (int k = 1; k <= 35; k++) begin
      if (tx_v[0] !== exp_line(b, 0, k)) bad++;
      if (k == 20) begin
        tx_en_v[0] = 1'b1;
        tx_byte = 8'h11;
        exp_q.push_back(8'h11);
      end else begin
        tx_en_v[0] = 1'b0;
      end
      if (k == 35) begin
        checks++;
        if (busy_v[0] !== 1'b1) $display("FAIL mid_reset_held: tx_busy got %b required 1", busy_v[0]);
        else passed++;
        rst_n = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    checks++;
    if (bad != 0) $display("FAIL mid_reset_partial: %0d bad tx cycles, required 0", bad);
    else passed++;
    @(negedge clk);
    checks++;
    if ({tx_v[0], act_v[0], busy_v[0], done_v[0]} !== 4'b1000)
      $display("FAIL mid_reset_edge: tx/active/busy/done got %b required 1000",
               {tx_v[0], act_v[0], busy_v[0], done_v[0]});
    else
      passed++;
    rst_n = 1'b1;
    exp_q.delete();
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (tx_v[0] !== 1'b1 || done_v[0] !== 1'b0 || act_v[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL mid_reset_quiet: %0d active cycles after reset, required 0", bad);
    else passed++;
    $display("mid-frame reset during data bit 3 of c3 with 11 held");
    start_byte(0, 8'h5A);
    check_frame(0, 0, 1, 0, 8'h00, 0, "after_reset_5a");
    check_idle(0, "after_reset");
  endtask

  task automatic test_random();
    logic [7:0] nb;
    int ik;
    start_byte(0, 8'($urandom));
    for (int i = 0; i < 4; i++) begin
      nb = 8'($urandom);
      ik = (i < 3) ? int'($urandom_range(80, 1)) : 0;
      check_frame(0, 0, 1, ik, nb, 0, "random");
    end
    check_idle(0, "random");
  endtask

  initial begin
    rst_n   = 1'b0;
    tx_en_v = 3'b111;
    tx_byte = 8'hFF;
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_end_accept();
    test_parity();
    test_overrun();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_byte_tx.md
# uart_byte_tx

Byte-wide UART transmitter for the 100 MHz control domain. It takes bytes from the control FSM or the readout FIFO and serialises them onto the host TX line as start, data (LSB first), optional parity and stop bits. It has a one-byte holding register, so the next byte can be accepted mid-frame and sent back-to-back with no idle gap.

## Interface
- CLK_FREQ, 100_000_000, clock frequency in Hz
- BAUD, 115200, line rate; bit period DIV = round(CLK_FREQ/BAUD) cycles (868 at defaults); DIV ≥ 2
- DATA_BITS, 8, data bits per frame, 5..8
- PARITY, 0, 0 none / 1 odd / 2 even
- STOP_BITS, 1, 1 or 2
- clk_100  in  1  system clock; single clock domain
- Reset_n  in  1  synchronous, active-low reset
- tx_en  in  1  byte-valid strobe; accepted when tx_en && !tx_busy
- tx_byte  in  8  data; bits above DATA_BITS-1 ignored
- tx  out  1  serial line, idle high
- tx_busy  out  1  holding register full; new bytes refused
- tx_active  out  1  a frame is on the line (state ≠ IDLE)
- tx_done  out  1  one-cycle pulse at the end of each frame's last stop bit
- tx_overrun  out  1  one-cycle pulse when tx_en arrives while tx_busy

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Every state holds for exactly DIV cycles per bit.
- IDLE:
  - tx=1.
  - An accepted byte loads straight into the shift register and moves to START; the holding register stays empty.
- START: tx=0.
- DATA:
  - tx=shift[0], shifting right each bit period.
  - A bit counter runs 0..DATA_BITS-1, then moves to PARITY if PARITY≠0, else STOP.
- PARITY:
  - Even: tx = XOR of the data bits.
  - Odd: tx = inverted XOR.
- STOP: tx=1 for STOP_BITS periods.
- End of the last stop bit:
  - tx_done pulses.
  - If the holding register is full, its byte moves to the shift register, the register clears, and the FSM enters START on the next cycle with no gap.
  - Otherwise the FSM returns to IDLE.
- Accept while state≠IDLE: the byte is written to the holding register and tx_busy rises.
- Simultaneous accept and frame end, with the holding register empty: the byte goes directly to the shift register, START follows, and tx_busy stays 0.
- tx_en while tx_busy: the byte is dropped, tx_overrun pulses, and the frame in flight is unaffected.
- Baud counter: width $clog2(DIV). It restarts at 0 on every frame start, so bit timing is independent of tx_en phase.

## Timing
- Reset values: tx=1, tx_busy=0, tx_active=0, tx_done=0, tx_overrun=0. State is IDLE and the holding register is empty.
- Reset mid-frame: the line is forced to 1 on the next edge, the in-flight and held bytes are discarded, and no tx_done is issued.
- Latency: accept at edge N means tx=0 from edge N+1.
- Frame length: DIV×(1+DATA_BITS+(PARITY≠0)+STOP_BITS) cycles.
- tx_done is high during the final cycle of the last stop bit.
- tx_busy: rises the cycle after an accept made during a frame; falls the cycle after the held byte moves to the shift register.
- All outputs are registered.

## Structure
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - parity constants PAR_NONE / PAR_ODD / PAR_EVEN;
  - a constant function calc_div(CLK_FREQ, BAUD) that rounds to nearest.
- Sub-module baud_tick_gen: counter with restart input and a one-cycle tick every DIV cycles. The FSM, shift register and holding register live in the top module.

## Test plan
Common setup: BAUD=12_500_000 (DIV=8) unless stated.
- Reset: hold Reset_n low 3 cycles with tx_en=1 → tx=1, all flags 0, nothing sent after release.
- Single byte, PARITY=0, tx_byte=0xA5:
  - tx=0 for cycles 1–8;
  - data bits 1,0,1,0,0,1,0,1 at 8 cycles each;
  - stop high for 8 cycles;
  - tx_done at cycle 80.
- Back-to-back: 0x00, then 0xFF accepted at cycle 20 → tx_busy=1 from cycle 21 to 80, second start bit at cycle 81, both frames intact, 160 cycles total.
- Parity with 0x07:
  - PARITY=2 → parity bit 1;
  - PARITY=1 → parity bit 0;
  - STOP_BITS=2 → frame 96 cycles.
- Overrun: with tx_busy=1, pulse tx_en with 0x33 → tx_overrun pulses once; only the two earlier bytes appear on tx.
- Mid-frame reset: assert Reset_n low during data bit 3 of 0xC3 with 0x11 held → tx=1 next edge, tx_active=0, tx_busy=0, no tx_done; a following 0x5A transmits correctly.
